frame_stop_sequencer: RTL and testbench

//  Stop/go initiator for the capture stop latch. Watches camera frame-valid, lets SKIP_FRAMES

---
 rtl/frame_stop_pkg.sv | 23 ++
 rtl/fval_edge_detect.sv | 34 +++
 rtl/frame_stop_sequencer.sv | 158 +++++++++++++++
 tb/tb_frame_stop_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stop_pkg.sv
// Shared constants for the frame stop sequencer: state encoding, default
// parameter values and a counter-width helper.
package frame_stop_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_RUN       = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT_STOP = 3'd2;
  localparam logic [STATE_W-1:0] S_FROZEN    = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT_GO   = 3'd4;
  localparam logic [STATE_W-1:0] S_LOCKED    = 3'd5;

  localparam int DEF_SKIP_FRAMES = 1;
  localparam int DEF_TIMEOUT     = 16;
  localparam int DEF_CNT_W       = 16;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fval_edge_detect.sv
// Frame-valid edge tracker: registers iFVAL, flags the falling edge and
// remembers whether the current frame started while the sequencer was running.
module fval_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_fval,
  input  logic i_run,
  output logic o_fall,
  output logic o_frame_open
);

  logic r_fval_d;
  logic r_open;
  logic w_rise;

  assign w_rise = i_fval & ~r_fval_d;
  assign o_fall = ~i_fval & r_fval_d;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fval_d <= 1'b0;
      r_open   <= 1'b0;
    end else begin
      r_fval_d <= i_fval;
      // Only frames whose start was seen while running can later count.
      r_open   <= i_run & (w_rise | (r_open & ~o_fall));
    end
  end

  assign o_frame_open = r_open;

endmodule

// File: rtl/frame_stop_sequencer.sv
// Stop/go initiator for the capture stop latch: freezes the buffer at a frame
// end after a number of skipped frames, then restarts capture on release.
module frame_stop_sequencer
  import frame_stop_pkg::*;
#(
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFVAL,
  input  logic               iEnable,
  input  logic               iRelease,
  input  logic               iStopped,
  output logic               oStop,
  output logic               oGo,
  output logic               oFrameReady,
  output logic               oExtStop,
  output logic               oLocked,
  output logic [CNT_W-1:0]   oFrameCount,
  output logic [STATE_W-1:0] oState
);

  localparam int TIMER_W = width_for(TIMEOUT);
  localparam int SKIP_W  = width_for(SKIP_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
  localparam logic [SKIP_W-1:0]  SKIP_LOAD = SKIP_W'(SKIP_FRAMES);

  logic [STATE_W-1:0] r_state, w_state_next;
  logic [TIMER_W-1:0] r_timer, w_timer_inc;
  logic [SKIP_W-1:0]  r_skip, w_skip_next;
  logic [CNT_W-1:0]   r_count;
  logic r_stop, r_go, r_ready, r_ext, r_locked;
  logic w_stop_next, w_go_next, w_ready_next, w_ext_next, w_locked_next;
  logic w_in_run, w_fall, w_frame_open, w_frame_end, w_timeout, w_retry;

  assign w_in_run = (r_state == S_RUN);

  fval_edge_detect u_edge (
    .i_clk        (iCLK),
    .i_rst_n      (iRST),
    .i_fval       (iFVAL),
    .i_run        (w_in_run),
    .o_fall       (w_fall),
    .o_frame_open (w_frame_open)
  );

  assign w_frame_end = w_in_run & w_fall & w_frame_open;
  assign w_timer_inc = (r_timer == TIMER_MAX) ? TIMER_MAX : r_timer + 1'b1;
  assign w_timeout   = (w_timer_inc == TIMER_MAX);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_skip_next   = r_skip;
    w_stop_next   = 1'b0;
    w_go_next     = 1'b0;
    w_ready_next  = r_ready;
    w_ext_next    = r_ext;
    w_locked_next = r_locked;
    w_retry       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iEnable && !iStopped) begin
          w_state_next = S_RUN;
          w_skip_next  = SKIP_LOAD;
        end
      end
      S_RUN: begin
        // A frame end outranks both an external stop and a disable.
        if (w_frame_end) begin
          if (r_skip == '0) begin
            w_stop_next  = 1'b1;
            w_state_next = S_WAIT_STOP;
          end else begin
            w_skip_next = r_skip - 1'b1;
          end
        end else if (iStopped) begin
          w_state_next = S_FROZEN;
          w_ext_next   = 1'b1;
          w_ready_next = 1'b1;
        end else if (!iEnable) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_STOP: begin
        if (iStopped) begin
          w_state_next = S_FROZEN;
          w_ready_next = 1'b1;
        end else if (w_timeout) begin
          w_stop_next = 1'b1;
          w_retry     = 1'b1;
        end
      end
      S_FROZEN: begin
        if (iRelease) begin
          w_go_next    = 1'b1;
          w_ready_next = 1'b0;
          w_ext_next   = 1'b0;
          w_state_next = S_WAIT_GO;
        end
      end
      S_WAIT_GO: begin
        if (!iStopped) begin
          w_state_next = iEnable ? S_RUN : S_IDLE;
          w_skip_next  = SKIP_LOAD;
        end else if (w_timeout) begin
          w_state_next  = S_LOCKED;
          w_locked_next = 1'b1;
        end
      end
      S_LOCKED: begin
        w_state_next = S_LOCKED;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_skip   <= SKIP_LOAD;
      r_count  <= '0;
      r_stop   <= 1'b0;
      r_go     <= 1'b0;
      r_ready  <= 1'b0;
      r_ext    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_skip   <= w_skip_next;
      r_stop   <= w_stop_next;
      r_go     <= w_go_next;
      r_ready  <= w_ready_next;
      r_ext    <= w_ext_next;
      r_locked <= w_locked_next;
      // Each state entry and each stop retry restarts the handshake window.
      r_timer  <= ((w_state_next != r_state) || w_retry) ? '0 : w_timer_inc;
      if (w_frame_end) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign oStop       = r_stop;
  assign oGo         = r_go;
  assign oFrameReady = r_ready;
  assign oExtStop    = r_ext;
  assign oLocked     = r_locked;
  assign oFrameCount = r_count;
  assign oState      = r_state;

endmodule

// File: tb/tb_frame_stop_sequencer.sv
// Self-checking bench for frame_stop_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_frame_stop_sequencer;

  localparam int SKIP = 1;
  localparam int TMO  = 16;
  localparam int CW   = 4;

  logic iCLK = 1'b0;
  logic iRST = 1'b0, iFVAL = 1'b0, iEnable = 1'b0, iRelease = 1'b0, iStopped = 1'b0;
  logic oStop, oGo, oFrameReady, oExtStop, oLocked;
  logic [CW-1:0] oFrameCount;
  logic [2:0] oState;

  frame_stop_sequencer #(.SKIP_FRAMES(SKIP), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iEnable(iEnable), .iRelease(iRelease),
    .iStopped(iStopped), .oStop(oStop), .oGo(oGo), .oFrameReady(oFrameReady),
    .oExtStop(oExtStop), .oLocked(oLocked), .oFrameCount(oFrameCount), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phases numbered as the documented debug encoding,
  // handshake windows tracked as absolute deadline cycles.
  localparam int P_OFF = 0, P_ARMED = 1, P_STOPPING = 2, P_HELD = 3, P_RESUMING = 4, P_DEAD = 5;
  int m_phase = P_OFF, m_skip_left = SKIP, m_count = 0, m_deadline = 0, m_cyc = 0;
  bit m_stop = 0, m_go = 0, m_ready = 0, m_ext = 0, m_locked = 0, m_prev = 0, m_in_frame = 0;

  task automatic model_step();
    int ph;
    bit rise, fall, fend;
    ph = m_phase;
    m_stop = 0;
    m_go   = 0;
    if (!iRST) begin
      m_phase = P_OFF; m_skip_left = SKIP; m_count = 0;
      m_ready = 0; m_ext = 0; m_locked = 0; m_prev = 0; m_in_frame = 0;
    end else begin
      rise = iFVAL && !m_prev;
      fall = !iFVAL && m_prev;
      fend = (ph == P_ARMED) && fall && m_in_frame;
      case (ph)
        P_OFF: if (iEnable && !iStopped) begin m_phase = P_ARMED; m_skip_left = SKIP; end
        P_ARMED: begin
          if (fend) begin
            m_count = (m_count + 1) % (1 << CW);
            if (m_skip_left == 0) begin
              m_stop = 1; m_phase = P_STOPPING; m_deadline = m_cyc + TMO;
            end else m_skip_left--;
          end else if (iStopped) begin
            m_phase = P_HELD; m_ext = 1; m_ready = 1;
          end else if (!iEnable) m_phase = P_OFF;
        end
        P_STOPPING: begin
          if (iStopped) begin m_phase = P_HELD; m_ready = 1; end
          else if (m_cyc == m_deadline) begin m_stop = 1; m_deadline = m_cyc + TMO; end
        end
        P_HELD: if (iRelease) begin
          m_go = 1; m_ready = 0; m_ext = 0; m_phase = P_RESUMING; m_deadline = m_cyc + TMO;
        end
        P_RESUMING: begin
          if (!iStopped) begin m_phase = iEnable ? P_ARMED : P_OFF; m_skip_left = SKIP; end
          else if (m_cyc == m_deadline) begin m_phase = P_DEAD; m_locked = 1; end
        end
        default: ;
      endcase
      m_in_frame = (ph == P_ARMED) && (rise || (m_in_frame && !fall));
      m_prev = iFVAL;
    end
    m_cyc++;
  endtask

  task automatic compare_outputs();
    check($sformatf("cyc%0d oStop", m_cyc), oStop, m_stop);
    check($sformatf("cyc%0d oGo", m_cyc), oGo, m_go);
    check($sformatf("cyc%0d oFrameReady", m_cyc), oFrameReady, m_ready);
    check($sformatf("cyc%0d oExtStop", m_cyc), oExtStop, m_ext);
    check($sformatf("cyc%0d oLocked", m_cyc), oLocked, m_locked);
    check($sformatf("cyc%0d oFrameCount", m_cyc), oFrameCount, m_count);
    check($sformatf("cyc%0d oState", m_cyc), oState, m_phase);
  endtask

  // Stop latch environment: 0 = stop sets / go clears, 1 = go ignored, 2 = latch frozen.
  int lat_mode = 0;
  bit lat = 0;

  task automatic tick();
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
    compare_outputs();
    iStopped = lat;
    if (lat_mode != 2) begin
      if (oStop) lat = 1;
      else if (oGo && lat_mode == 0) lat = 0;
    end
  endtask

  task automatic frame(input int hi, input int lo);
    iFVAL = 1'b1;
    repeat (hi) tick();
    iFVAL = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (oState !== s && n < budget) begin tick(); n++; end
    check(name, oState, s);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " outputs"}, {oStop, oGo, oFrameReady, oExtStop, oLocked}, 5'b0);
    check({name, " count"}, oFrameCount, 0);
    check({name, " state"}, oState, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fval_left;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    iRST = 1'b1; iEnable = 1'b1;
    tick();
    check("enter run", oState, 1);

    // Two frames with one skipped: stop one cycle after the second fall
    frame(3, 3);
    iFVAL = 1'b1; repeat (3) tick();
    iFVAL = 1'b0; tick();
    check("stop after 2nd frame", oStop, 1);
    check("count after 2 frames", oFrameCount, 2);
    check("model count pinned", m_count, 2);
    check("wait_stop state", oState, 2);
    tick();
    check("stop is one cycle", oStop, 0);
    tick();
    check("frame ready", oFrameReady, 1);
    check("frozen state", oState, 3);

    // Release in FROZEN, then release ignored in RUN
    iRelease = 1'b1; tick(); iRelease = 1'b0;
    check("go after release", oGo, 1);
    check("ready cleared", oFrameReady, 0);
    check("wait_go state", oState, 4);
    tick();
    check("go is one cycle", oGo, 0);
    tick();
    check("back to run", oState, 1);
    iRelease = 1'b1; tick(); iRelease = 1'b0;
    check("release in run ignored", oGo, 0);

    // Enable while a frame is already open: its fall is not counted
    iEnable = 1'b0; tick();
    check("disable to idle", oState, 0);
    iFVAL = 1'b1; repeat (2) tick();
    iEnable = 1'b1; tick();
    check("re-enter run", oState, 1);
    repeat (2) tick();
    iFVAL = 1'b0; tick();
    check("mid-frame fall not counted", oFrameCount, 2);
    tick();
    check("no stop for partial frame", oStop, 0);

    // External stop while running
    lat = 1; tick(); tick();
    check("ext stop state", oState, 3);
    check("ext stop flag", oExtStop, 1);
    check("ext stop ready", oFrameReady, 1);
    iRelease = 1'b1; tick(); iRelease = 1'b0;
    check("ext flag cleared on release", oExtStop, 0);
    wait_state(3'd1, 10, "run after ext release");

    // Stop ignored: retry after TIMEOUT cycles
    lat_mode = 2;
    frame(3, 3);
    iFVAL = 1'b1; repeat (3) tick();
    iFVAL = 1'b0; tick();
    check("first stop", oStop, 1);
    check("count before retry", oFrameCount, 4);
    n = 0;
    do begin tick(); n++; end while (oStop !== 1'b1 && n < 40);
    check("stop retry gap", n, TMO);
    lat_mode = 0; lat = 1;
    wait_state(3'd3, 5, "freeze after retry");

    // Go ignored: lock TIMEOUT cycles after entering WAIT_GO
    lat_mode = 1;
    iRelease = 1'b1; tick(); iRelease = 1'b0;
    check("go before lock", oGo, 1);
    n = 0;
    do begin tick(); n++; end while (oLocked !== 1'b1 && n < 40);
    check("lock delay", n, TMO);
    check("locked state", oState, 5);
    for (int i = 0; i < 40; i++) begin
      iRelease = (i % 5 == 0);
      iFVAL = ((i % 7) < 3);
      tick();
      check("locked quiet", {oStop, oGo, oLocked}, 3'b001);
    end
    iRelease = 1'b0; iFVAL = 1'b0;

    // Reset in the middle of WAIT_GO
    lat = 0; lat_mode = 0; iRST = 1'b0; tick();
    iRST = 1'b1; tick();
    frame(3, 1);
    frame(3, 1);
    wait_state(3'd3, 10, "frozen before reset test");
    lat_mode = 1;
    iRelease = 1'b1; tick(); iRelease = 1'b0;
    repeat (3) tick();
    check("in wait_go before reset", oState, 4);
    lat = 0; iRST = 1'b0; tick();
    check_all_zero("reset in wait_go");
    lat_mode = 0; iRST = 1'b1;

    // Randomized traffic against the model
    fval_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        n = $urandom_range(0, 9);
        lat_mode = (n < 7) ? 0 : ((n < 9) ? 1 : 2);
      end
      if (fval_left == 0) begin
        iFVAL = ~iFVAL;
        fval_left = $urandom_range(1, 6);
      end
      fval_left--;
      iRelease = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 79) == 0) iEnable = ~iEnable;
      if ($urandom_range(0, 199) == 0) lat = 1;
      iRST = !((m_locked && $urandom_range(0, 29) == 0) || $urandom_range(0, 1499) == 0);
      if (!iRST) lat = 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
